// File: rtl/sram_bridge_if.sv
// LSU-side request/response bundle between the MEM stage (master) and the SRAM bridge (slave).
interface sram_bridge_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  bmask;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;

  modport master (
    output req, we, addr, wdata, bmask,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, we, addr, wdata, bmask,
    output rdata, ack, busy
  );
endinterface

// File: rtl/sram_bridge.sv
// Bridge one 32-bit byte-masked LSU access onto a 16-bit asynchronous SRAM as one or two beats,
// with programmable wait states and a stall/ack handshake toward the pipeline.
module sram_bridge #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  sram_bridge_if.slave      lsu,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_sram_dq_o,
  output logic              o_sram_dq_oe,
  input  logic [15:0]       i_sram_dq_i,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  logic [1:0]      r_state;
  logic [3:0]      r_cnt;
  logic            r_hold;
  logic            r_we;
  logic [ADDR_W:2] r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_bmask;
  logic [31:0]     r_rdata;

  logic       w_in_beat;
  logic       w_hi;
  logic       w_beat_end;
  logic [1:0] w_lane_en;
  logic       w_unused;

  assign w_in_beat = (r_state == S_LO) || (r_state == S_HI);
  assign w_hi      = (r_state == S_HI);
  assign w_lane_en = w_hi ? r_bmask[3:2] : r_bmask[1:0];

  // The 4-bit counter covers the WAIT_CYCLES+1 strobe cycles; the extra write
  // hold cycle is tracked by r_hold so WAIT_CYCLES=15 still fits.
  assign w_beat_end = w_in_beat && (r_cnt == LP_WAIT) && (!r_we || r_hold);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hold  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_bmask <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (lsu.req) begin
            r_we    <= lsu.we;
            r_addr  <= lsu.addr[ADDR_W:2];
            r_wdata <= lsu.wdata;
            r_bmask <= lsu.bmask;
            r_cnt   <= '0;
            r_hold  <= 1'b0;
            if (!lsu.we) begin
              r_rdata <= '0;
            end
            if (lsu.bmask[1:0] != 2'b00) begin
              r_state <= S_LO;
            end else if (lsu.bmask[3:2] != 2'b00) begin
              r_state <= S_HI;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_LO, S_HI: begin
          if (w_beat_end) begin
            r_cnt  <= '0;
            r_hold <= 1'b0;
            if (!r_we) begin
              if (w_hi) begin
                if (r_bmask[2]) r_rdata[23:16] <= i_sram_dq_i[7:0];
                if (r_bmask[3]) r_rdata[31:24] <= i_sram_dq_i[15:8];
              end else begin
                if (r_bmask[0]) r_rdata[7:0]  <= i_sram_dq_i[7:0];
                if (r_bmask[1]) r_rdata[15:8] <= i_sram_dq_i[15:8];
              end
            end
            if (!w_hi && (r_bmask[3:2] != 2'b00)) begin
              r_state <= S_HI;
            end else begin
              r_state <= S_DONE;
            end
          end else if (r_cnt == LP_WAIT) begin
            r_hold <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_sram_addr  = {r_addr, w_hi};
  assign o_sram_dq_o  = w_hi ? r_wdata[31:16] : r_wdata[15:0];
  assign o_sram_dq_oe = w_in_beat && r_we;
  assign o_sram_ce_n  = !w_in_beat;
  assign o_sram_oe_n  = !(w_in_beat && !r_we);
  assign o_sram_we_n  = !(w_in_beat && r_we && !r_hold);
  assign o_sram_lb_n  = !(w_in_beat && w_lane_en[0]);
  assign o_sram_ub_n  = !(w_in_beat && w_lane_en[1]);

  assign lsu.rdata = r_rdata;
  assign lsu.ack   = (r_state == S_DONE);
  assign lsu.busy  = !i_rst && (w_in_beat || ((r_state == S_IDLE) && lsu.req));

  assign w_unused = ^{lsu.addr[31:ADDR_W+1], lsu.addr[1:0]};

endmodule

// File: tb/tb_sram_bridge.sv
// Randomised and directed bench for sram_bridge: two instances (WAIT_CYCLES=1 and 0) share one SRAM model.
module tb_sram_bridge;

  typedef struct packed {
    logic [17:0] a;
    logic        we;
    logic        oe;
    logic        lb;
    logic        ub;
    logic        dqoe;
    logic [15:0] dq;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic req, we;
  logic [31:0] addr, wdata;
  logic [3:0] bmask;

  always #5 clk = ~clk;

  sram_bridge_if if0 ();
  sram_bridge_if if1 ();

  assign if0.req = req && !sel;
  assign if1.req = req && sel;
  assign if0.we = we;     assign if1.we = we;
  assign if0.addr = addr; assign if1.addr = addr;
  assign if0.wdata = wdata; assign if1.wdata = wdata;
  assign if0.bmask = bmask; assign if1.bmask = bmask;

  logic [17:0] a0, a1;
  logic [15:0] d0, d1;
  logic dqoe0, dqoe1, ce0, ce1, oe0, oe1, we0, we1, lb0, lb1, ub0, ub1;
  logic [15:0] dq_in;

  sram_bridge #(.ADDR_W(18), .WAIT_CYCLES(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .lsu(if0),
    .o_sram_addr(a0), .o_sram_dq_o(d0), .o_sram_dq_oe(dqoe0), .i_sram_dq_i(dq_in),
    .o_sram_ce_n(ce0), .o_sram_oe_n(oe0), .o_sram_we_n(we0), .o_sram_lb_n(lb0), .o_sram_ub_n(ub0)
  );

  sram_bridge #(.ADDR_W(18), .WAIT_CYCLES(0)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .lsu(if1),
    .o_sram_addr(a1), .o_sram_dq_o(d1), .o_sram_dq_oe(dqoe1), .i_sram_dq_i(dq_in),
    .o_sram_ce_n(ce1), .o_sram_oe_n(oe1), .o_sram_we_n(we1), .o_sram_lb_n(lb1), .o_sram_ub_n(ub1)
  );

  wire [17:0] m_addr  = sel ? a1 : a0;
  wire [15:0] m_dq    = sel ? d1 : d0;
  wire        m_dqoe  = sel ? dqoe1 : dqoe0;
  wire        m_ce    = sel ? ce1 : ce0;
  wire        m_oe    = sel ? oe1 : oe0;
  wire        m_we    = sel ? we1 : we0;
  wire        m_lb    = sel ? lb1 : lb0;
  wire        m_ub    = sel ? ub1 : ub0;
  wire        m_ack   = sel ? if1.ack : if0.ack;
  wire        m_busy  = sel ? if1.busy : if0.busy;
  wire [31:0] m_rdata = sel ? if1.rdata : if0.rdata;

  // SRAM model: 1024 halfwords, commits a write on the we_n rising edge while still selected.
  logic [15:0] mem [0:1023];
  logic [7:0]  refm [0:2047];
  logic [31:0] last_rd [0:1];
  rec_t        cq[$];
  int          ack_cnt, idle_bad;
  int          n_cmp = 0, n_err = 0;
  logic        filled = 1'b0, prev_we = 1'b1;
  logic        pk_en = 1'b0;
  logic [9:0]  pk_a;
  logic [15:0] pk_d;

  assign dq_in = (!m_ce && !m_oe) ? mem[m_addr[9:0]] : 16'hA5C3;

  function automatic logic [15:0] init_hw(int h);
    return 16'(h * 40503) ^ 16'h5A3C;
  endfunction

  always @(negedge clk) begin
    rec_t r;
    if (!filled) begin
      for (int h = 0; h < 1024; h++) mem[h] = init_hw(h);
      filled = 1'b1;
    end
    if (pk_en) mem[pk_a] = pk_d;
    if (m_ack) ack_cnt++;
    if (!m_ce) begin
      r.a = m_addr; r.we = m_we; r.oe = m_oe; r.lb = m_lb; r.ub = m_ub;
      r.dqoe = m_dqoe; r.dq = m_dq;
      cq.push_back(r);
      if (!prev_we && m_we) begin
        if (!m_lb) mem[m_addr[9:0]][7:0]  = m_dq[7:0];
        if (!m_ub) mem[m_addr[9:0]][15:8] = m_dq[15:8];
      end
    end else if (m_oe !== 1'b1 || m_we !== 1'b1 || m_lb !== 1'b1 || m_ub !== 1'b1 || m_dqoe !== 1'b0) begin
      idle_bad++;
    end
    prev_we = m_we;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(logic [31:0] a, logic [3:0] m);
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++)
      if (m[k]) r[8*k +: 8] = refm[{a[10:2], 2'(k)}];
    return r;
  endfunction

  task automatic poke(input logic [9:0] hw, input logic [15:0] d);
    refm[{hw, 1'b0}] = d[7:0];
    refm[{hw, 1'b1}] = d[15:8];
    pk_a = hw; pk_d = d; pk_en = 1'b1;
    @(negedge clk); #1;
    pk_en = 1'b0;
  endtask

  task automatic run_xact(input logic s, input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] m, output int lat, output logic [31:0] rd);
    int wt, blen, nb, c, idx, bad;
    logic [31:0] exp_rd;
    logic [17:0] ea;
    logic bb, exp_we;
    rec_t r;
    wt   = s ? 0 : 1;
    blen = w ? wt + 2 : wt + 1;
    nb   = int'(m[1:0] != 2'b00) + int'(m[3:2] != 2'b00);
    exp_rd = w ? last_rd[s] : ref_load(a, m);
    if (w) for (int k = 0; k < 4; k++) if (m[k]) refm[{a[10:2], 2'(k)}] = wd[8*k +: 8];
    @(negedge clk);
    cq.delete(); idle_bad = 0; ack_cnt = 0;
    sel = s; req = 1'b1; we = w; addr = a; wdata = wd; bmask = m;
    #1 check_eq("busy_on_req", m_busy, 1);
    c = 0; bad = 0;
    while (c < 100) begin
      @(negedge clk);
      c++;
      if (m_ack) break;
      if (m_busy !== 1'b1) bad++;
    end
    lat = c; rd = m_rdata;
    check_eq("ack_seen", m_ack, 1);
    check_eq("latency", c, 1 + nb * blen);
    check_eq("busy_during", bad, 0);
    check_eq("busy_at_ack", m_busy, 0);
    check_eq(w ? "rdata_after_store" : "rdata_load", rd, exp_rd);
    req = 1'b0;
    @(negedge clk); #1;
    check_eq("ack_pulses", ack_cnt, 1);
    check_eq("rdata_hold", m_rdata, exp_rd);
    check_eq("idle_strobes", idle_bad, 0);
    idx = 0; bad = 0;
    for (int b = 0; b < 2; b++) begin
      if (b == 0 ? (m[1:0] != 2'b00) : (m[3:2] != 2'b00)) begin
        for (int j = 0; j < blen; j++) begin
          if (idx < cq.size()) begin
            r  = cq[idx];
            bb = (b == 1);
            ea = {a[18:2], bb};
            exp_we = w ? (j == blen - 1) : 1'b1;
            if (r.a !== ea) bad++;
            if (r.lb !== ~m[2*b]) bad++;
            if (r.ub !== ~m[2*b+1]) bad++;
            if (r.oe !== w) bad++;
            if (r.we !== exp_we) bad++;
            if (r.dqoe !== w) bad++;
            if (w && r.dq !== wd[16*b +: 16]) bad++;
          end
          idx++;
        end
      end
    end
    check_eq("beat_cycles", cq.size(), idx);
    check_eq("beat_strobes", bad, 0);
    last_rd[s] = exp_rd;
  endtask

  initial begin
    int lat, c, ack1, ack2;
    logic [31:0] rd, rd1, rd2, a_1, a_2, e1, e2, ra, rw;
    logic [15:0] old10, old11;
    logic rs, rwe;
    logic [3:0] rm;

    for (int h = 0; h < 1024; h++) begin
      logic [15:0] v;
      v = init_hw(h);
      refm[{10'(h), 1'b0}] = v[7:0];
      refm[{10'(h), 1'b1}] = v[15:8];
    end
    last_rd[0] = '0; last_rd[1] = '0;
    rst = 1'b1; sel = 1'b0; req = 1'b1; we = 1'b0; addr = '0; wdata = '0; bmask = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check_eq("rst_busy", m_busy, 0);
      check_eq("rst_ack", m_ack, 0);
      check_eq("rst_rdata", m_rdata, 0);
      check_eq("rst_addr", m_addr, 0);
      check_eq("rst_strobes", {m_ce, m_oe, m_we, m_lb, m_ub, m_dqoe}, 6'b111110);
    end
    req = 1'b0; sel = 1'b0; rst = 1'b0;
    @(negedge clk);

    // Word load across halfwords 0x82/0x83.
    poke(10'h082, 16'hBEEF);
    poke(10'h083, 16'hDEAD);
    run_xact(1'b0, 1'b0, 32'h0000_0104, '0, 4'hF, lat, rd);
    check_eq("t1_lat", lat, 5);
    check_eq("t1_rdata", rd, 32'hDEAD_BEEF);

    // Word store then direct model inspection and readback.
    run_xact(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, lat, rd);
    check_eq("t2_lat", lat, 7);
    check_eq("t2_mem_lo", mem[8], 16'h5678);
    check_eq("t2_mem_hi", mem[9], 16'h1234);
    run_xact(1'b0, 1'b0, 32'h0000_0010, '0, 4'hF, lat, rd);
    check_eq("t2_readback", rd, 32'h1234_5678);

    // Byte store to lane 2 only.
    old10 = mem[10'h010]; old11 = mem[10'h011];
    run_xact(1'b0, 1'b1, 32'h0000_0020, 32'h00AB_0000, 4'b0100, lat, rd);
    check_eq("t3_lat", lat, 4);
    check_eq("t3_mem_hw", mem[10'h011], {old11[15:8], 8'hAB});
    check_eq("t3_mem_other", mem[10'h010], old10);

    // Zero-mask load.
    run_xact(1'b0, 1'b0, 32'h0000_0104, '0, 4'h0, lat, rd);
    check_eq("t4_lat", lat, 1);
    check_eq("t4_rdata", rd, 0);

    // Reset in the middle of a two-beat write.
    @(negedge clk);
    ack_cnt = 0; idle_bad = 0;
    sel = 1'b0; req = 1'b1; we = 1'b1; addr = 32'h0000_0040; wdata = 32'hCAFE_F00D; bmask = 4'hF;
    @(negedge clk); @(negedge clk);
    check_eq("t5_we_low", m_we, 0);
    rst = 1'b1; req = 1'b0;
    #1 check_eq("t5_busy_rst", m_busy, 0);
    @(negedge clk);
    check_eq("t5_strobes", {m_ce, m_oe, m_we, m_lb, m_ub, m_dqoe}, 6'b111110);
    check_eq("t5_addr", m_addr, 0);
    check_eq("t5_rdata", m_rdata, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("t5_no_ack", ack_cnt, 0);
    last_rd[0] = '0; last_rd[1] = '0;
    run_xact(1'b0, 1'b0, 32'h0000_0104, '0, 4'hF, lat, rd);
    check_eq("t5_recover", rd, 32'hDEAD_BEEF);

    // Back-to-back loads with WAIT_CYCLES=0 and req held high.
    a_1 = 32'h0000_0200; a_2 = 32'h0000_0304;
    e1 = ref_load(a_1, 4'hF); e2 = ref_load(a_2, 4'hF);
    @(negedge clk);
    ack_cnt = 0; ack1 = -1; ack2 = -1; rd1 = '0; rd2 = '0;
    sel = 1'b1; req = 1'b1; we = 1'b0; addr = a_1; bmask = 4'hF;
    for (c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (m_ack) begin
        if (ack1 < 0) begin
          ack1 = c; rd1 = m_rdata; addr = a_2;
        end else if (ack2 < 0) begin
          ack2 = c; rd2 = m_rdata; req = 1'b0;
        end
      end
    end
    req = 1'b0;
    @(negedge clk);
    check_eq("t6_ack1", ack1, 3);
    check_eq("t6_ack2", ack2, 7);
    check_eq("t6_rd1", rd1, e1);
    check_eq("t6_rd2", rd2, e2);
    check_eq("t6_acks", ack_cnt, 2);
    last_rd[1] = e2;

    // Random traffic on both wait-state settings.
    for (int i = 0; i < 40; i++) begin
      rs  = 1'($urandom);
      rwe = 1'($urandom);
      rm  = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      ra  = $urandom;
      ra[18:11] = '0;
      rw  = $urandom;
      run_xact(rs, rwe, ra, rw, rm, lat, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
